// File: rtl/cfg_chain_loader.sv
// Daisy-chained configuration loader: forwards every beat to the next tile and
// writes its own frame's words to local memory. Optional trailer parity: CFG_CHAIN_LOADER_PARITY_EN.
module cfg_chain_loader #(
    parameter int LANES     = 4,
    parameter int ID_W      = 4,
    parameter int WORD_W    = 8,
    parameter int MEM_WORDS = 16,
    parameter int TILE_ID   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0]             data_in,
    input  logic                         data_valid,
    output logic [LANES-1:0]             data_out,
    output logic                         data_valid_out,
    output logic                         mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    output logic                         done,
    output logic                         err
);

    localparam int HDR_BEATS  = ID_W / LANES;
    localparam int WORD_BEATS = WORD_W / LANES;
    localparam int AW         = $clog2(MEM_WORDS);
    localparam int BEAT_MAX   = (HDR_BEATS > WORD_BEATS) ? HDR_BEATS : WORD_BEATS;
    localparam int BW         = (BEAT_MAX > 1) ? $clog2(BEAT_MAX) : 1;

    localparam logic [BW-1:0]   HDR_LAST  = BW'(HDR_BEATS - 1);
    localparam logic [BW-1:0]   WORD_LAST = BW'(WORD_BEATS - 1);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(MEM_WORDS - 1);
    localparam logic [ID_W-1:0] OWN_ID    = ID_W'(TILE_ID);

`ifdef CFG_CHAIN_LOADER_PARITY_EN
    typedef enum logic [1:0] {HDR, LOAD, SKIP, TRAIL} state_t;
`else
    typedef enum logic [1:0] {HDR, LOAD, SKIP} state_t;
`endif

    state_t            state_q;
    logic [BW-1:0]     beatCnt_q;
    logic [AW-1:0]     wordCnt_q;
    logic [LANES-1:0]  dataOut_q;
    logic              dataValidOut_q;
    logic              memWe_q;
    logic [AW-1:0]     memAddr_q;
    logic [WORD_W-1:0] memWdata_q;
    logic              done_q;
    logic [ID_W-1:0]   hdrNext;
    logic [WORD_W-1:0] wordNext;

    // Only the already-received upper beats are stored; the current beat
    // completes the value combinationally so the decision is made on its last beat.
    if (HDR_BEATS > 1) begin : gHdrShift
        logic [ID_W-LANES-1:0] hdrPart_q;
        always_ff @(posedge clk) begin
            if (!rst)
                hdrPart_q <= '0;
            else if (data_valid && state_q == HDR)
                hdrPart_q <= hdrNext[ID_W-LANES-1:0];
        end
        assign hdrNext = {hdrPart_q, data_in};
    end else begin : gHdrDirect
        assign hdrNext = data_in;
    end

    if (WORD_BEATS > 1) begin : gWordShift
        logic [WORD_W-LANES-1:0] wordPart_q;
        always_ff @(posedge clk) begin
            if (!rst)
                wordPart_q <= '0;
            else if (data_valid && (state_q == LOAD || state_q == SKIP))
                wordPart_q <= wordNext[WORD_W-LANES-1:0];
        end
        assign wordNext = {wordPart_q, data_in};
    end else begin : gWordDirect
        assign wordNext = data_in;
    end

`ifdef CFG_CHAIN_LOADER_PARITY_EN
    logic parity_q;
    logic trailLoad_q;
    logic err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= HDR;
            beatCnt_q      <= '0;
            wordCnt_q      <= '0;
            dataOut_q      <= '0;
            dataValidOut_q <= 1'b0;
            memWe_q        <= 1'b0;
            memAddr_q      <= '0;
            memWdata_q     <= '0;
            done_q         <= 1'b0;
`ifdef CFG_CHAIN_LOADER_PARITY_EN
            parity_q       <= 1'b0;
            trailLoad_q    <= 1'b0;
            err_q          <= 1'b0;
`endif
        end else begin
            dataOut_q      <= data_in;
            dataValidOut_q <= data_valid;
            memWe_q        <= 1'b0;
            if (data_valid) begin
                case (state_q)
                    HDR: begin
                        if (beatCnt_q == HDR_LAST) begin
                            beatCnt_q <= '0;
                            wordCnt_q <= '0;
`ifdef CFG_CHAIN_LOADER_PARITY_EN
                            parity_q  <= 1'b0;
`endif
                            state_q   <= (hdrNext == OWN_ID || &hdrNext) ? LOAD : SKIP;
                        end else begin
                            beatCnt_q <= beatCnt_q + BW'(1);
                        end
                    end
                    // Skipped frames walk the same counters so both end on the same beat.
                    LOAD, SKIP: begin
`ifdef CFG_CHAIN_LOADER_PARITY_EN
                        parity_q <= parity_q ^ (^data_in);
`endif
                        if (beatCnt_q == WORD_LAST) begin
                            beatCnt_q <= '0;
                            if (state_q == LOAD) begin
                                memWe_q    <= 1'b1;
                                memAddr_q  <= wordCnt_q;
                                memWdata_q <= wordNext;
`ifndef CFG_CHAIN_LOADER_PARITY_EN
                                if (wordCnt_q == LAST_ADDR)
                                    done_q <= 1'b1;
`endif
                            end
                            if (wordCnt_q == LAST_ADDR) begin
                                wordCnt_q <= '0;
`ifdef CFG_CHAIN_LOADER_PARITY_EN
                                trailLoad_q <= (state_q == LOAD);
                                state_q     <= TRAIL;
`else
                                state_q     <= HDR;
`endif
                            end else begin
                                wordCnt_q <= wordCnt_q + AW'(1);
                            end
                        end else begin
                            beatCnt_q <= beatCnt_q + BW'(1);
                        end
                    end
`ifdef CFG_CHAIN_LOADER_PARITY_EN
                    TRAIL: begin
                        if (trailLoad_q) begin
                            if (data_in[LANES-1] == parity_q)
                                done_q <= 1'b1;
                            else
                                err_q <= 1'b1;
                        end
                        state_q <= HDR;
                    end
`endif
                    default: state_q <= HDR;
                endcase
            end
        end
    end

    assign data_out       = dataOut_q;
    assign data_valid_out = dataValidOut_q;
    assign mem_we         = memWe_q;
    assign mem_addr       = memAddr_q;
    assign mem_wdata      = memWdata_q;
    assign done           = done_q;
`ifdef CFG_CHAIN_LOADER_PARITY_EN
    assign err            = err_q;
`else
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader (LANES=4, ID_W=4, WORD_W=8, MEM_WORDS=4, TILE_ID=2);
// optional trailer scenarios follow CFG_CHAIN_LOADER_PARITY_EN.
module tb_cfg_chain_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] data_in;
    logic       data_valid;
    logic [3:0] data_out;
    logic       data_valid_out;
    logic       mem_we;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       done;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    string      phase  = "init";
    logic       expDone;
    logic       expErr;
    logic [1:0] lastAddr;
    logic [7:0] lastData;
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef CFG_CHAIN_LOADER_PARITY_EN
    logic       flipNext;
`endif

    cfg_chain_loader #(
        .LANES(4), .ID_W(4), .WORD_W(8), .MEM_WORDS(4), .TILE_ID(2)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_out(data_out), .data_valid_out(data_valid_out), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, tag, observed, expected);
        end
    endtask

    // Drive one cycle, then sample just after the edge that registered it.
    task automatic applyStimulus(input logic [3:0] d, input logic v, input logic expWe,
                                 input logic [1:0] expAddr, input logic [7:0] expData);
        data_in    = d;
        data_valid = v;
        @(posedge clk);
        #1;
        if (expWe) begin
            lastAddr = expAddr;
            lastData = expData;
        end
        checkOutput("data_out", 32'(data_out), 32'(d));
        checkOutput("data_valid_out", 32'(data_valid_out), 32'(v));
        checkOutput("mem_we", 32'(mem_we), 32'(expWe));
        checkOutput("mem_addr", 32'(mem_addr), 32'(lastAddr));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(lastData));
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("err", 32'(err), 32'(expErr));
    endtask

    task automatic gapCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(4'h6, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic doReset();
        rst        = 1'b0;
        data_in    = 4'hF;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_data_out", 32'(data_out), 32'h0);
        checkOutput("rst_data_valid_out", 32'(data_valid_out), 32'h0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        rst      = 1'b1;
        expDone  = 1'b0;
        expErr   = 1'b0;
        lastAddr = 2'd0;
        lastData = 8'h00;
    endtask

    // Payload 11,22,33,44 sent high nibble first; trailer 5 has even parity bit 0, D flips it.
    task automatic sendFrame(input logic [3:0] hdr, input int gaps, input logic load);
        logic [3:0] nib;
        logic       we;
        applyStimulus(hdr, 1'b1, 1'b0, 2'd0, 8'h00);
        gapCycles(gaps);
        for (int p = 0; p < 8; p++) begin
            nib = (p % 2 == 0) ? words[p/2][7:4] : words[p/2][3:0];
            we  = load && (p % 2 == 1);
`ifndef CFG_CHAIN_LOADER_PARITY_EN
            if (we && p == 7)
                expDone = 1'b1;
`endif
            applyStimulus(nib, 1'b1, we, 2'(p / 2), words[p/2]);
            gapCycles(gaps);
        end
`ifdef CFG_CHAIN_LOADER_PARITY_EN
        if (load) begin
            if (flipNext)
                expErr = 1'b1;
            else
                expDone = 1'b1;
        end
        applyStimulus(flipNext ? 4'hD : 4'h5, 1'b1, 1'b0, 2'd0, 8'h00);
        gapCycles(gaps);
`endif
    endtask

    initial begin
        rst        = 1'b0;
        data_in    = 4'h0;
        data_valid = 1'b0;
        expDone    = 1'b0;
        expErr     = 1'b0;
        lastAddr   = 2'd0;
        lastData   = 8'h00;
`ifdef CFG_CHAIN_LOADER_PARITY_EN
        flipNext   = 1'b0;
`endif
        phase = "reset";
        doReset();

        phase = "skip5";
`ifdef CFG_CHAIN_LOADER_PARITY_EN
        flipNext = 1'b1;
`endif
        sendFrame(4'h5, 0, 1'b0);
`ifdef CFG_CHAIN_LOADER_PARITY_EN
        flipNext = 1'b0;
`endif

        phase = "own2";
        sendFrame(4'h2, 0, 1'b1);

        phase = "bcastF";
        sendFrame(4'hF, 0, 1'b1);

        phase = "gaps";
        sendFrame(4'h2, 3, 1'b1);

        phase = "midReset";
        doReset();
        applyStimulus(4'h2, 1'b1, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'h1, 1'b1, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'h1, 1'b1, 1'b1, 2'd0, 8'h11);
        applyStimulus(4'h2, 1'b1, 1'b0, 2'd0, 8'h00);
        doReset();
        sendFrame(4'h2, 0, 1'b1);

`ifdef CFG_CHAIN_LOADER_PARITY_EN
        phase = "badParity";
        doReset();
        flipNext = 1'b1;
        sendFrame(4'h2, 0, 1'b1);
        flipNext = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfg_chain_loader.md
CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  LANES, 4, serial bits accepted per beat.
  ID_W, 4, tile-id header width; multiple of LANES.
  WORD_W, 8, configuration word width; multiple of LANES.
  MEM_WORDS, 16, words per frame payload.
  TILE_ID, 0, this tile's id; header value all-ones is broadcast.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-low reset.
  data_in  in  LANES  beat data, bit LANES-1 first in stream order.
  data_valid  in  1  beat qualifier; low = stall.
  data_out  out  LANES  registered copy of data_in for the next tile.
  data_valid_out  out  1  registered copy of data_valid.
  mem_we  out  1  one-cycle write strobe.
  mem_addr  out  clog2(MEM_WORDS)  write address.
  mem_wdata  out  WORD_W  write data.
  done  out  1  sticky; own frame fully loaded.
  err  out  1  sticky parity error.

Function
REQ-003 Stream SHALL be back-to-back frames: HDR_BEATS=ID_W/LANES header beats, then PAY_BEATS=MEM_WORDS*WORD_W/LANES payload beats, then a trailer beat when parity is enabled (REQ-014).
REQ-004 FSM states SHALL be HDR, LOAD, SKIP, TRAIL; the reset state is HDR.
REQ-005 State and beat counters SHALL advance only on cycles with data_valid=1; data_valid=0 holds all state.
REQ-006 HDR SHALL assemble the header MSB-first; after the last header beat, go to LOAD if header==TILE_ID or header=={ID_W{1}}, else go to SKIP.
REQ-007 LOAD SHALL assemble words MSB-first, with addresses from 0 ascending; the cycle after each word's final beat, mem_we=1 with that word's mem_addr and mem_wdata.
REQ-008 After the last payload beat, LOAD and SKIP SHALL go to TRAIL if parity is enabled, else to HDR.
REQ-009 done SHALL set on the cycle mem_we fires for address MEM_WORDS-1 (parity off), or at the end of a passing trailer (parity on); done stays high until reset.
REQ-010 A second matching frame SHALL reload memory from address 0; done remains 1.
REQ-011 data_out and data_valid_out SHALL equal the previous cycle's data_in and data_valid for every beat, including own-frame beats: fixed 1-cycle forwarding latency.
REQ-012 mem_we SHALL be 0 in every cycle not specified by REQ-007; mem_addr and mem_wdata hold their last values otherwise.

Reset
REQ-013 On a clk edge with rst=0: FSM goes to HDR; all counters and the word buffer clear; data_out=0, data_valid_out=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0. A reset mid-frame discards the partial frame, and the next valid beat is treated as a header beat.

Configuration
REQ-014 Macro CFG_CHAIN_LOADER_PARITY_EN defined: each frame carries one trailer beat, and its bit LANES-1 is even parity over all payload bits of that frame. In a loading frame, a mismatch sets err (sticky) and leaves done unchanged; a match sets done. Skipped frames' trailers are ignored.
REQ-015 Macro CFG_CHAIN_LOADER_PARITY_EN undefined: there is no TRAIL state and no trailer beat, and err is constant 0.

Verification
REQ-016 Every scenario SHALL use LANES=4, ID_W=4, WORD_W=8, MEM_WORDS=4, TILE_ID=2.
REQ-017 Frame: header 4'h2, payload 11,22,33,44 (hex), data_valid=1 continuously -> mem_we pulses with (0,0x11), (1,0x22), (2,0x33), (3,0x44) on the cycle after beats 3, 5, 7, 9; done=1 with the last write.
REQ-018 Frame: header 4'h5 -> no mem_we, done=0, FSM returns to HDR after 9 beats, and data_out reproduces all beats with 1-cycle latency.
REQ-019 Frame: header 4'hF -> loads exactly as in REQ-017.
REQ-020 The REQ-017 frame with data_valid=0 inserted for 3 cycles after every beat -> identical writes and values; data_valid_out mirrors the gaps.
REQ-021 rst=0 for one cycle after payload beat 3, then the REQ-017 frame is sent -> writes start again at address 0 and the partial data is not written.
REQ-022 With parity enabled, the REQ-017 frame with a correct trailer gives done=1 and err=0; the same frame with a flipped trailer gives err=1 and done=0.
